// File: rtl/xcvr_reconfig_pkg.sv
// Shared types and constants for the transceiver reconfiguration arbiter.
package xcvr_reconfig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  localparam logic [31:0] READ_TIMEOUT_DATA = 32'hDEADBEEF;
  localparam int          BE_W              = 4;
  localparam int          DATA_W            = 32;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xcvr_reconfig_arbiter_rr_grant.sv
// Combinational round-robin selector: first pending index after the last grant,
// wrapping modulo NUM_REQ.
module rr_grant
  import xcvr_reconfig_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_vld
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return IDX_W'(sum % NUM_REQ);
  endfunction

  // Walk farthest-to-nearest so the nearest pending index is the last one written.
  always_comb begin
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_pending[wrap_idx(i_last_grant, k)]) begin
        o_grant_idx = wrap_idx(i_last_grant, k);
        o_grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xcvr_reconfig_arbiter.sv
// Round-robin arbiter sharing one reconfig management port between NUM_REQ masters.
//   state   | meaning
//   IDLE    | pick next requester, latch its command
//   ISSUE   | drive command downstream until m_waitrequest drops
//   WAIT_RD | hold the port until read data returns or the timeout fires
module xcvr_reconfig_arbiter
  import xcvr_reconfig_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic                      m_read,
  output logic                      m_write,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_writedata,
  output logic [BE_W-1:0]           m_byteenable,
  input  logic [DATA_W-1:0]         m_readdata,
  input  logic                      m_readdatavalid,
  input  logic                      m_waitrequest,
  output logic                      timeout_err,
  input  logic                      err_clear
);

  localparam int               IDX_W    = idx_width(NUM_REQ);
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_vld;
  logic [CNT_W-1:0]   r_tmo_cnt;
  logic [NUM_REQ-1:0] w_pending;
  logic               w_take;
  logic               w_accept;
  logic               w_rd_data;
  logic               w_rd_tmo;

  assign w_pending = req_read | req_write;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .i_pending    (w_pending),
    .i_last_grant (r_last_grant),
    .o_grant_idx  (w_gnt_idx),
    .o_grant_vld  (w_gnt_vld)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_take          = 1'b0;
    w_accept        = 1'b0;
    w_rd_data       = 1'b0;
    w_rd_tmo        = 1'b0;
    req_waitrequest = '1;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_take      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          w_accept               = 1'b1;
          req_waitrequest[r_gnt] = 1'b0;
          w_state_nxt            = m_write ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        // Real data beats the timeout when both land in the same cycle.
        if (m_readdatavalid) begin
          w_rd_data   = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_tmo_cnt == CNT_LAST) begin
          w_rd_tmo    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt             <= '0;
      r_last_grant      <= IDX_LAST;
      r_tmo_cnt         <= '0;
      m_read            <= 1'b0;
      m_write           <= 1'b0;
      m_address         <= '0;
      m_writedata       <= '0;
      m_byteenable      <= '0;
      req_readdata      <= '0;
      req_readdatavalid <= '0;
    end else begin
      req_readdatavalid <= '0;
      if (w_take) begin
        r_gnt        <= w_gnt_idx;
        m_address    <= req_address[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
        m_writedata  <= req_writedata[int'(w_gnt_idx)*DATA_W +: DATA_W];
        m_byteenable <= req_byteenable[int'(w_gnt_idx)*BE_W +: BE_W];
        m_write      <= req_write[w_gnt_idx];
        m_read       <= req_read[w_gnt_idx] & ~req_write[w_gnt_idx];
      end
      if (w_accept) begin
        m_read       <= 1'b0;
        m_write      <= 1'b0;
        r_last_grant <= r_gnt;
        r_tmo_cnt    <= '0;
      end
      if (r_state == WAIT_RD && !w_rd_data && !w_rd_tmo) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
      if (w_rd_data) begin
        req_readdata             <= m_readdata;
        req_readdatavalid[r_gnt] <= 1'b1;
      end
      if (w_rd_tmo) begin
        req_readdata             <= READ_TIMEOUT_DATA;
        req_readdatavalid[r_gnt] <= 1'b1;
      end
    end
  end

  // Setting the flag takes priority over a clear in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       timeout_err <= 1'b0;
    else if (w_rd_tmo)  timeout_err <= 1'b1;
    else if (err_clear) timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_xcvr_reconfig_arbiter.sv
// Directed bench for xcvr_reconfig_arbiter with two requesters and a 16-cycle read timeout.
module tb_xcvr_reconfig_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int TMO     = 16;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*32-1:0]     req_writedata;
  logic [NUM_REQ*4-1:0]      req_byteenable;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [31:0]               req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic                      m_read;
  logic                      m_write;
  logic [ADDR_W-1:0]         m_address;
  logic [31:0]               m_writedata;
  logic [3:0]                m_byteenable;
  logic [31:0]               m_readdata;
  logic                      m_readdatavalid;
  logic                      m_waitrequest;
  logic                      timeout_err;
  logic                      err_clear;

  int n_total = 0;
  int n_bad   = 0;

  xcvr_reconfig_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_writedata     (req_writedata),
    .req_byteenable    (req_byteenable),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_address         (m_address),
    .m_writedata       (m_writedata),
    .m_byteenable      (m_byteenable),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .m_waitrequest     (m_waitrequest),
    .timeout_err       (timeout_err),
    .err_clear         (err_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_read[i]                 = rd;
    req_write[i]                = wr;
    req_address[i*ADDR_W +: 32] = a;
    req_writedata[i*32 +: 32]   = d;
    req_byteenable[i*4 +: 4]    = be;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_read"},   32'(m_read), 32'h0);
    check({tag, "_m_write"},  32'(m_write), 32'h0);
    check({tag, "_m_addr"},   m_address, 32'h0);
    check({tag, "_m_wdata"},  m_writedata, 32'h0);
    check({tag, "_m_be"},     32'(m_byteenable), 32'h0);
    check({tag, "_wrq"},      32'(req_waitrequest), 32'h3);
    check({tag, "_rdv"},      32'(req_readdatavalid), 32'h0);
    check({tag, "_rdata"},    req_readdata, 32'h0);
    check({tag, "_tmo_err"},  32'(timeout_err), 32'h0);
  endtask

  task automatic do_reset();
    next_cyc();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_vals("rst");
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hi, n_low, n_acc, n_p, n_p0, p_cyc, n_stale;
    reset_n         = 1'b0;
    req_read        = '0;
    req_write       = '0;
    req_address     = '0;
    req_writedata   = '0;
    req_byteenable  = '0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
    m_waitrequest   = 1'b0;
    err_clear       = 1'b0;
    do_reset();

    // Single write with three stalled cycles downstream.
    next_cyc();
    set_req(0, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF);
    m_waitrequest = 1'b1;
    @(negedge clock);
    check("wr_idle_m_write", 32'(m_write), 32'h0);
    n_hi  = 0;
    n_low = 0;
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      if (i == 3) m_waitrequest = 1'b0;
      if (i == 4) set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clock);
      if (m_write) begin
        n_hi++;
        check("wr_addr_stable", m_address, 32'h0000_0040);
      end
      if (!req_waitrequest[0]) begin
        n_low++;
        check("wr_wdata", m_writedata, 32'h1234_5678);
        check("wr_be", 32'(m_byteenable), 32'hF);
      end
      check("wr_wrq1_high", 32'(req_waitrequest[1]), 32'h1);
    end
    check("wr_m_write_cycles", n_hi, 4);
    check("wr_wrq0_low_count", n_low, 1);

    // Contention: both write continuously, grants alternate from requester 0.
    do_reset();
    next_cyc();
    set_req(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_00A0, 4'h3);
    set_req(1, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_00B1, 4'hC);
    n_acc = 0;
    for (int i = 0; i < 16 && n_acc < 4; i++) begin
      @(negedge clock);
      if (req_waitrequest != 2'b11) begin
        check($sformatf("ct_wrq_%0d", n_acc), 32'(req_waitrequest),
              (n_acc % 2 == 1) ? 32'h1 : 32'h2);
        check($sformatf("ct_addr_%0d", n_acc), m_address,
              (n_acc % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
        n_acc++;
      end
      next_cyc();
    end
    check("ct_accepts", n_acc, 4);
    req_write = '0;

    // Read from requester 1, data 7 cycles after accept; spurious valids earlier.
    n_p = 0; n_p0 = 0; p_cyc = -1;
    for (int c = 0; c < 14; c++) begin
      next_cyc();
      m_readdatavalid = (c == 0 || c == 1 || c == 8);
      m_readdata      = (c == 8) ? 32'hA5A5_0001 : 32'hBAD0_BAD0;
      if (c == 0) set_req(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
      if (c == 2) set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clock);
      if (c == 1) begin
        check("rd_wrq", 32'(req_waitrequest), 32'h1);
        check("rd_m_read", 32'(m_read), 32'h1);
        check("rd_addr", m_address, 32'h0000_0010);
      end
      if (req_readdatavalid[1]) begin
        n_p++;
        p_cyc = c;
        check("rd_data", req_readdata, 32'hA5A5_0001);
      end
      if (req_readdatavalid[0]) n_p0++;
    end
    m_readdatavalid = 1'b0;
    check("rd_pulses1", n_p, 1);
    check("rd_pulse_cycle", p_cyc, 9);
    check("rd_pulses0", n_p0, 0);

    // Unanswered read from requester 0; clear coincides with the timeout.
    n_p = 0; p_cyc = -1;
    for (int c = 0; c < 24; c++) begin
      next_cyc();
      err_clear = (c == 17 || c == 22);
      if (c == 0) set_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
      if (c == 2) set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clock);
      if (req_readdatavalid != 2'b00) begin
        n_p++;
        p_cyc = c;
        check("tmo_rdv_mask", 32'(req_readdatavalid), 32'h1);
        check("tmo_data", req_readdata, 32'hDEAD_BEEF);
      end
      if (c == 16) check("tmo_err_before", 32'(timeout_err), 32'h0);
      if (c == 18) check("tmo_err_set_wins", 32'(timeout_err), 32'h1);
      if (c == 21) check("tmo_err_sticky", 32'(timeout_err), 32'h1);
      if (c == 23) check("tmo_err_cleared", 32'(timeout_err), 32'h0);
    end
    err_clear = 1'b0;
    check("tmo_pulses", n_p, 1);
    check("tmo_pulse_cycle", p_cyc, 18);

    // Data arrives on the exact timeout cycle: real data, no error.
    n_p = 0; p_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      next_cyc();
      m_readdatavalid = (c == 17);
      m_readdata      = (c == 17) ? 32'h5A5A_0017 : 32'h0;
      if (c == 0) set_req(1, 1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'hF);
      if (c == 2) set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clock);
      if (req_readdatavalid != 2'b00) begin
        n_p++;
        p_cyc = c;
        check("edge_rdv_mask", 32'(req_readdatavalid), 32'h2);
        check("edge_data", req_readdata, 32'h5A5A_0017);
      end
    end
    m_readdatavalid = 1'b0;
    check("edge_pulses", n_p, 1);
    check("edge_pulse_cycle", p_cyc, 18);
    check("edge_tmo_err", 32'(timeout_err), 32'h0);

    // Reset during WAIT_RD, stale data afterwards, then requester 0 wins.
    n_stale = 0;
    for (int c = 0; c < 13; c++) begin
      next_cyc();
      reset_n         = !(c == 4 || c == 5);
      m_readdatavalid = (c == 7);
      m_readdata      = 32'hBAAD_F00D;
      if (c == 0) set_req(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
      if (c == 2) set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (c == 9) begin
        set_req(0, 1'b0, 1'b1, 32'h0000_0100, 32'h1, 4'hF);
        set_req(1, 1'b0, 1'b1, 32'h0000_0200, 32'h2, 4'hF);
      end
      if (c == 11) req_write = '0;
      @(negedge clock);
      if (c == 3) check("mr_in_flight", 32'(m_read | (req_waitrequest != 2'b11)), 32'h0);
      if (c == 4) check_reset_vals("mr");
      if (c >= 6 && c <= 9 && req_readdatavalid != 2'b00) n_stale++;
      if (c == 10) begin
        check("mr_next_grant", 32'(req_waitrequest), 32'h2);
        check("mr_next_addr", m_address, 32'h0000_0100);
      end
    end
    m_readdatavalid = 1'b0;
    check("mr_stale_dropped", n_stale, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
